// File: rtl/oled_pkg.sv
// Shared types and constants for the OLED panel-side SPI receiver.
package oled_pkg;

  // Tag carried alongside every received byte.
  localparam logic DC_CMD  = 1'b0;
  localparam logic DC_DATA = 1'b1;

  // Width of one queued entry: {dc, byte}.
  localparam int ENTRY_W = 9;

  typedef enum logic {
    IDLE,
    SHIFT
  } rx_state_t;

  // Translate the sampled dc_n pin level into the queued tag.
  function automatic logic dc_tag(input logic dc_n);
    return dc_n ? DC_DATA : DC_CMD;
  endfunction

endpackage

// File: rtl/oled_spi_sink_if.sv
// Received-byte stream: head-of-queue byte with valid/ready handshake.
interface oled_spi_sink_if;
  logic [7:0] rx_data;
  logic       rx_dc;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_dc, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_dc, input rx_valid, output rx_ready);
endinterface

// File: rtl/oled_spi_sink_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; the head entry is visible
// whenever the FIFO is non-empty and reads as zero when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_rd, do_wr;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // A write into a full FIFO is allowed when the head leaves in the same cycle.
  assign do_rd     = rd_en_i & ~empty_o;
  assign do_wr     = wr_en_i & (~full_o | do_rd);
  assign rd_data_o = empty_o ? '0 : mem[rd_ptr_q[AW-1:0]];

  // Read and write pointers, one extra wrap bit to tell full from empty.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage array; contents are masked by empty so no reset is needed.
  always_ff @(posedge clock) begin
    if (do_wr) mem[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/oled_spi_sink.sv
// Panel-side SPI receiver: synchronises the OLED pins, deserialises bytes
// MSB-first, queues {dc, byte} and keeps sticky error flags.
module oled_spi_sink
  import oled_pkg::*;
#(
  parameter int FIFO_DEPTH   = 16,
  parameter int SYNC_STAGES  = 2,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  oled_spi_clk,
  input  logic                  oled_spi_data,
  input  logic                  oled_dc_n,
  input  logic                  oled_vdd,
  input  logic                  oled_vbat,
  input  logic                  oled_reset_n,
  oled_spi_sink_if.master       rx,
  input  logic                  clear_status,
  output logic                  overflow,
  output logic                  frame_err,
  output logic                  seq_err,
  output logic                  panel_on,
  output logic [15:0]           byte_count
);

  localparam int P_SCLK  = 5;
  localparam int P_SDATA = 4;
  localparam int P_DC    = 3;
  localparam int P_VDD   = 2;
  localparam int P_VBAT  = 1;
  localparam int P_RSTN  = 0;
  // The SPI clock idles high, so its synchroniser resets high to avoid a
  // phantom rising edge right after reset.
  localparam logic [5:0] SYNC_RST = 6'b100000;
  localparam int TW = $clog2(IDLE_TIMEOUT) + 1;
  localparam logic [TW-1:0] TIMER_MAX = TW'(IDLE_TIMEOUT - 1);

  logic [5:0] pins;
  logic [5:0] sync_q [SYNC_STAGES];
  logic       sclk_s, sdata_s, dc_s, vdd_s, vbat_s, rstn_s, powered;
  logic       sclk_prev_q, edge_q, sdata_q, dc_q;

  rx_state_t         state_q, state_d;
  logic [2:0]        bitcnt_q, bitcnt_d;
  logic [6:0]        shift_q, shift_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              push, seq_set, frame_set;
  logic [ENTRY_W-1:0] push_data, head;
  logic              fifo_full, fifo_empty, pop, push_ok, drop;
  logic              overflow_q, frame_err_q, seq_err_q;
  logic [15:0]       byte_count_q;

  assign pins = {oled_spi_clk, oled_spi_data, oled_dc_n, oled_vdd, oled_vbat, oled_reset_n};

  // Multi-flop synchroniser chain for all panel pins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
    end else begin
      sync_q[0] <= pins;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sclk_s  = sync_q[SYNC_STAGES-1][P_SCLK];
  assign sdata_s = sync_q[SYNC_STAGES-1][P_SDATA];
  assign dc_s    = sync_q[SYNC_STAGES-1][P_DC];
  assign vdd_s   = sync_q[SYNC_STAGES-1][P_VDD];
  assign vbat_s  = sync_q[SYNC_STAGES-1][P_VBAT];
  assign rstn_s  = sync_q[SYNC_STAGES-1][P_RSTN];
  assign powered = ~vdd_s & rstn_s;

  // Registered rising-edge detect with data and dc captured alongside it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sclk_prev_q <= 1'b1;
      edge_q      <= 1'b0;
      sdata_q     <= 1'b0;
      dc_q        <= 1'b0;
    end else begin
      sclk_prev_q <= sclk_s;
      edge_q      <= sclk_s & ~sclk_prev_q;
      sdata_q     <= sdata_s;
      dc_q        <= dc_s;
    end
  end

  // Receiver state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      shift_q  <= '0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      timer_q  <= timer_d;
    end
  end

  // Next-state logic: shift on powered edges, time out stalled bytes,
  // and abandon any partial byte while the panel is held in reset.
  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    timer_d   = timer_q;
    push      = 1'b0;
    frame_set = 1'b0;
    seq_set   = edge_q & ~powered;
    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        if (edge_q && powered) begin
          shift_d  = {6'b0, sdata_q};
          bitcnt_d = 3'd1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (edge_q && powered) begin
          shift_d = {shift_q[5:0], sdata_q};
          timer_d = '0;
          if (bitcnt_q == 3'd7) begin
            push     = 1'b1;
            bitcnt_d = '0;
            state_d  = IDLE;
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end else if (timer_q == TIMER_MAX) begin
          frame_set = 1'b1;
          bitcnt_d  = '0;
          timer_d   = '0;
          state_d   = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (!rstn_s) begin
      state_d   = IDLE;
      bitcnt_d  = '0;
      timer_d   = '0;
      frame_set = 1'b0;
    end
  end

  assign push_data = {dc_tag(dc_q), shift_q, sdata_q};
  assign pop       = ~fifo_empty & rx.rx_ready;
  assign push_ok   = push & (~fifo_full | pop);
  assign drop      = push & fifo_full & ~pop;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .wr_en_i   (push),
    .wr_data_i (push_data),
    .rd_en_i   (pop),
    .rd_data_o (head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign rx.rx_valid = ~fifo_empty;
  assign rx.rx_dc    = head[8];
  assign rx.rx_data  = head[7:0];

  // Sticky flags and accepted-byte counter; a new event beats clear_status.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      seq_err_q    <= 1'b0;
      byte_count_q <= '0;
    end else begin
      overflow_q  <= drop      | (overflow_q  & ~clear_status);
      frame_err_q <= frame_set | (frame_err_q & ~clear_status);
      seq_err_q   <= seq_set   | (seq_err_q   & ~clear_status);
      if (clear_status) byte_count_q <= push_ok ? 16'd1 : 16'd0;
      else if (push_ok) byte_count_q <= byte_count_q + 16'd1;
    end
  end

  assign overflow   = overflow_q;
  assign frame_err  = frame_err_q;
  assign seq_err    = seq_err_q;
  assign byte_count = byte_count_q;
  assign panel_on   = ~vdd_s & rstn_s & ~vbat_s;

endmodule

// File: tb/tb_oled_spi_sink.sv
// Self-checking bench for oled_spi_sink: drives SPI bytes at 5 MHz and
// compares the DUT against a queue-based model of the panel receiver.
module tb_oled_spi_sink;
  localparam int FIFO_DEPTH = 16;

  logic clock = 1'b0;
  logic reset;
  logic sclk, sdata, dcN, vdd, vbat, resetN, clearStatus;
  logic overflow, frameErr, seqErr, panelOn;
  logic [15:0] byteCount;

  oled_spi_sink_if rxIf ();

  oled_spi_sink #(.FIFO_DEPTH(FIFO_DEPTH), .SYNC_STAGES(2), .IDLE_TIMEOUT(1024)) dut (
    .clock        (clock),
    .reset        (reset),
    .oled_spi_clk (sclk),
    .oled_spi_data(sdata),
    .oled_dc_n    (dcN),
    .oled_vdd     (vdd),
    .oled_vbat    (vbat),
    .oled_reset_n (resetN),
    .rx           (rxIf.master),
    .clear_status (clearStatus),
    .overflow     (overflow),
    .frame_err    (frameErr),
    .seq_err      (seqErr),
    .panel_on     (panelOn),
    .byte_count   (byteCount)
  );

  // 100 MHz system clock.
  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  // Behavioural model: expected queue of {dc, byte}, flags and count.
  logic [8:0]  mq[$];
  logic [15:0] mCount;
  logic        mOvf, mFrame, mSeq;

  // One comparison; reports the actual and required values on mismatch.
  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Advance one clock; at the falling edge any pop the DUT is about to make
  // is checked against the head of the model queue.
  task automatic tick();
    logic [8:0] exp;
    @(negedge clock);
    if (!reset && rxIf.rx_valid && rxIf.rx_ready) begin
      if (mq.size() == 0) begin
        checkOutput("pop_unexpected", 16'd1, 16'd0);
      end else begin
        exp = mq.pop_front();
        checkOutput("pop_data", {8'h0, rxIf.rx_data}, {8'h0, exp[7:0]});
        checkOutput("pop_dc", {15'h0, rxIf.rx_dc}, {15'h0, exp[8]});
      end
    end
    @(posedge clock);
    #2;
  endtask

  // Send the first nBits of b MSB-first (10 clocks low, 10 high per bit) and
  // update the model on the final rising edge.
  task automatic applyStimulus(input logic [7:0] b, input int nBits, input logic dc);
    logic pw;
    pw = (vdd == 1'b0) && (resetN == 1'b1);
    for (int i = 0; i < nBits; i++) begin
      sclk  = 1'b0;
      sdata = b[7-i];
      dcN   = dc;
      repeat (10) tick();
      sclk = 1'b1;
      if (i == nBits - 1) begin
        if (!pw) mSeq = 1'b1;
        else if (nBits == 8) begin
          if (mq.size() < FIFO_DEPTH) begin
            mq.push_back({dc, b});
            mCount++;
          end else begin
            mOvf = 1'b1;
          end
        end
      end
      repeat (10) tick();
    end
  endtask

  // Single-cycle clear of sticky flags and byte counter.
  task automatic clearPulse();
    clearStatus = 1'b1;
    tick();
    clearStatus = 1'b0;
    mOvf = 1'b0; mFrame = 1'b0; mSeq = 1'b0; mCount = '0;
  endtask

  // Let the pipeline settle, then compare every output against the model.
  task automatic checkModel(input string tag);
    repeat (8) tick();
    checkOutput({tag, "_valid"}, {15'h0, rxIf.rx_valid}, {15'h0, mq.size() != 0});
    if (mq.size() != 0) begin
      checkOutput({tag, "_data"}, {8'h0, rxIf.rx_data}, {8'h0, mq[0][7:0]});
      checkOutput({tag, "_dc"}, {15'h0, rxIf.rx_dc}, {15'h0, mq[0][8]});
    end
    checkOutput({tag, "_count"}, byteCount, mCount);
    checkOutput({tag, "_ovf"}, {15'h0, overflow}, {15'h0, mOvf});
    checkOutput({tag, "_frame"}, {15'h0, frameErr}, {15'h0, mFrame});
    checkOutput({tag, "_seq"}, {15'h0, seqErr}, {15'h0, mSeq});
    checkOutput({tag, "_panel"}, {15'h0, panelOn},
                {15'h0, (vdd == 1'b0) && (resetN == 1'b1) && (vbat == 1'b0)});
  endtask

  // Pop everything the model still expects, within a bounded cycle budget.
  task automatic drain();
    int n = 0;
    rxIf.rx_ready = 1'b1;
    while (mq.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    checkOutput("drain_left", 16'(mq.size()), 16'd0);
  endtask

  // Main sequence: power-up, command/data traffic, random bytes, overflow,
  // power-sequence errors, idle timeout, and asynchronous reset.
  initial begin
    logic [7:0] rb;
    logic rdc;
    reset = 1'b1; sclk = 1'b1; sdata = 1'b0; dcN = 1'b0;
    vdd = 1'b0; vbat = 1'b0; resetN = 1'b1; clearStatus = 1'b0;
    rxIf.rx_ready = 1'b0;
    mCount = '0; mOvf = 1'b0; mFrame = 1'b0; mSeq = 1'b0;
    repeat (3) tick();
    checkOutput("rst_valid", {15'h0, rxIf.rx_valid}, 16'd0);
    checkOutput("rst_data", {8'h0, rxIf.rx_data}, 16'd0);
    checkOutput("rst_count", byteCount, 16'd0);
    checkOutput("rst_panel", {15'h0, panelOn}, 16'd0);
    reset = 1'b0;
    repeat (5) tick();

    // First command byte held in the FIFO.
    applyStimulus(8'hAE, 8, 1'b0);
    checkModel("first");
    checkOutput("first_lit_data", {8'h0, rxIf.rx_data}, 16'h00AE);
    checkOutput("first_lit_dc", {15'h0, rxIf.rx_dc}, 16'd0);
    checkOutput("first_lit_count", byteCount, 16'd1);
    checkOutput("first_lit_panel", {15'h0, panelOn}, 16'd1);
    drain();

    // Command followed by three data bytes, popped as they arrive.
    applyStimulus(8'h81, 8, 1'b0);
    applyStimulus(8'h7F, 8, 1'b1);
    applyStimulus(8'h00, 8, 1'b1);
    applyStimulus(8'hFF, 8, 1'b1);
    drain();
    checkModel("burst");
    checkOutput("burst_lit_count", byteCount, 16'd5);

    // Random bytes with random back-pressure; never enough to fill the FIFO.
    for (int k = 0; k < 12; k++) begin
      rxIf.rx_ready = 1'($urandom_range(0, 1));
      rb  = 8'($urandom);
      rdc = 1'($urandom);
      applyStimulus(rb, 8, rdc);
    end
    drain();
    checkModel("rand");

    // Overflow: 17 bytes into a 16-deep FIFO with no pops.
    clearPulse();
    rxIf.rx_ready = 1'b0;
    for (int k = 0; k < 17; k++) applyStimulus(8'(8'h30 + k), 8, 1'b1);
    checkModel("ovf");
    checkOutput("ovf_lit_count", byteCount, 16'd16);
    checkOutput("ovf_lit_flag", {15'h0, overflow}, 16'd1);
    checkOutput("ovf_lit_head", {8'h0, rxIf.rx_data}, 16'h0030);
    drain();
    clearPulse();
    checkModel("ovf_clr");
    checkOutput("ovf_clr_lit", {15'h0, overflow}, 16'd0);

    // Edges while vdd is off, then while the panel is held in reset.
    vdd = 1'b1;
    repeat (5) tick();
    applyStimulus(8'h55, 8, 1'b1);
    checkModel("seq_vdd");
    checkOutput("seq_vdd_lit", {15'h0, seqErr}, 16'd1);
    vdd = 1'b0;
    clearPulse();
    resetN = 1'b0;
    repeat (5) tick();
    applyStimulus(8'h66, 8, 1'b1);
    checkModel("seq_rst");
    resetN = 1'b1;
    repeat (5) tick();
    clearPulse();

    // Panel reset after 3 bits drops the partial byte without frame_err.
    applyStimulus(8'hFF, 3, 1'b0);
    resetN = 1'b0;
    repeat (10) tick();
    resetN = 1'b1;
    repeat (10) tick();
    applyStimulus(8'h3C, 8, 1'b0);
    drain();
    checkModel("rstn_pulse");
    checkOutput("rstn_lit_count", byteCount, 16'd1);

    // Leave seq_err set for the reset test below.
    vdd = 1'b1;
    repeat (5) tick();
    applyStimulus(8'h80, 1, 1'b0);
    vdd = 1'b0;
    repeat (5) tick();

    // Five bits then SCLK idles high: frame error after the timeout.
    rxIf.rx_ready = 1'b0;
    applyStimulus(8'hF0, 5, 1'b0);
    repeat (900) tick();
    checkOutput("frame_early", {15'h0, frameErr}, 16'd0);
    repeat (200) tick();
    checkOutput("frame_late", {15'h0, frameErr}, 16'd1);
    mFrame = 1'b1;
    applyStimulus(8'hA5, 8, 1'b1);
    checkModel("after_frame");
    checkOutput("after_frame_lit", {8'h0, rxIf.rx_data}, 16'h00A5);

    // Asynchronous reset with bytes queued and a byte in progress.
    applyStimulus(8'h11, 8, 1'b0);
    applyStimulus(8'h22, 8, 1'b1);
    applyStimulus(8'hC3, 3, 1'b1);
    reset = 1'b1;
    #1;
    checkOutput("arst_valid", {15'h0, rxIf.rx_valid}, 16'd0);
    checkOutput("arst_count", byteCount, 16'd0);
    checkOutput("arst_flags", {13'h0, overflow, frameErr, seqErr}, 16'd0);
    checkOutput("arst_panel", {15'h0, panelOn}, 16'd0);
    mq.delete();
    mCount = '0; mOvf = 1'b0; mFrame = 1'b0; mSeq = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    repeat (5) tick();
    applyStimulus(8'h5A, 8, 1'b1);
    checkModel("post_rst");
    drain();
    checkModel("end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
